// File: rtl/cr_su_mc_core_if.sv
// Bundle for cr_su_mc_core: per-channel scheduler-update inputs with credit
// return, plus the outbound AXI4-Stream beat with channel ID.
interface cr_su_mc_core_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 64,
    parameter int ID_W   = $clog2(N_CH)
);
    logic [N_CH-1:0]        su_in_valid;
    logic [N_CH*DATA_W-1:0] su_in_data;
    logic [N_CH-1:0]        su_in_last;
    logic [N_CH-1:0]        su_ready;
    logic                   ob_tready;
    logic                   ob_tvalid;
    logic [DATA_W-1:0]      ob_tdata;
    logic                   ob_tlast;
    logic [ID_W-1:0]        ob_tid;

    modport master (
        output su_in_valid, su_in_data, su_in_last, ob_tready,
        input  su_ready, ob_tvalid, ob_tdata, ob_tlast, ob_tid
    );

    modport slave (
        input  su_in_valid, su_in_data, su_in_last, ob_tready,
        output su_ready, ob_tvalid, ob_tdata, ob_tlast, ob_tid
    );
endinterface

// File: rtl/cr_su_mc_core.sv
// Multi-channel scheduler-update core: per-channel FIFOs, whole-frame round-robin
// onto one AXI4-Stream port. Optional entry parity under CR_SU_MC_PARITY_EN.
module cr_su_mc_core #(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 8,
    parameter int AFULL_SLOTS = 2,
    parameter int ID_W        = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    cr_su_mc_core_if.slave      bus,
    input  logic                force_ob_bp,
    input  logic                err_clr,
    output logic                frame_stb,
    output logic [N_CH-1:0]     ovfl_err,
    output logic                par_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef CR_SU_MC_PARITY_EN
    localparam int EW = DATA_W + 2;
`else
    localparam int EW = DATA_W + 1;
`endif
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_SLOTS);
    localparam logic [ID_W-1:0]  LAST_CH = ID_W'(N_CH - 1);

    typedef enum logic {S_IDLE, S_XFER} state_t;

    state_t            state;
    logic [EW-1:0]     mem [N_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N_CH];
    logic [PTR_W-1:0]  rd_ptr [N_CH];
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [CNT_W-1:0]  cnt_nxt [N_CH];
    logic [EW-1:0]     wr_entry [N_CH];
    logic [N_CH-1:0]   ne, push_ok, ovfl_set, pop_vec, su_ready_r;
    logic [ID_W-1:0]   rr_ptr, grant, arb_ch, cur_ch;
    logic              found, load_ok, pop, rd_last;
    logic [EW-1:0]     rd_entry;
    int unsigned       arb_idx;
    logic              ob_tvalid_r, ob_tlast_r;
    logic [DATA_W-1:0] ob_tdata_r;
    logic [ID_W-1:0]   ob_tid_r;

    assign bus.su_ready  = su_ready_r;
    assign bus.ob_tvalid = ob_tvalid_r;
    assign bus.ob_tdata  = ob_tdata_r;
    assign bus.ob_tlast  = ob_tlast_r;
    assign bus.ob_tid    = ob_tid_r;

    // In IDLE the arbiter's pick is popped in the same cycle it is granted.
    always_comb begin
        ne      = '0;
        found   = 1'b0;
        arb_ch  = rr_ptr;
        arb_idx = 0;
        for (int unsigned c = 0; c < N_CH; c++) ne[c] = (cnt[c] != '0);
        for (int unsigned i = 0; i < N_CH; i++) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= N_CH) arb_idx = arb_idx - N_CH;
            if (!found && ne[arb_idx]) begin
                found  = 1'b1;
                arb_ch = ID_W'(arb_idx);
            end
        end
        cur_ch  = (state == S_IDLE) ? arb_ch : grant;
        load_ok = (!ob_tvalid_r || bus.ob_tready) && !force_ob_bp;
        pop     = load_ok && ne[cur_ch];
        pop_vec = '0;
        if (pop) pop_vec[cur_ch] = 1'b1;
    end

    always_comb begin
        push_ok  = '0;
        ovfl_set = '0;
        cnt_nxt  = '{default: '0};
        wr_entry = '{default: '0};
        for (int unsigned c = 0; c < N_CH; c++) begin
            push_ok[c]  = bus.su_in_valid[c] && ((cnt[c] != DEPTH_C) || pop_vec[c]);
            ovfl_set[c] = bus.su_in_valid[c] && !push_ok[c];
            cnt_nxt[c]  = cnt[c] + CNT_W'(push_ok[c]) - CNT_W'(pop_vec[c]);
`ifdef CR_SU_MC_PARITY_EN
            wr_entry[c] = {^{bus.su_in_last[c], bus.su_in_data[c*DATA_W +: DATA_W]},
                           bus.su_in_last[c], bus.su_in_data[c*DATA_W +: DATA_W]};
`else
            wr_entry[c] = {bus.su_in_last[c], bus.su_in_data[c*DATA_W +: DATA_W]};
`endif
        end
    end

    assign rd_entry = mem[cur_ch][rd_ptr[cur_ch]];
    assign rd_last  = rd_entry[DATA_W];

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < N_CH; c++)
            if (push_ok[c]) mem[c][wr_ptr[c]] <= wr_entry[c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            wr_ptr      <= '{default: '0};
            rd_ptr      <= '{default: '0};
            cnt         <= '{default: '0};
            su_ready_r  <= '0;
            ob_tvalid_r <= 1'b0;
            ob_tdata_r  <= '0;
            ob_tlast_r  <= 1'b0;
            ob_tid_r    <= '0;
            frame_stb   <= 1'b0;
            ovfl_err    <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop_vec[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
                cnt[c]        <= cnt_nxt[c];
                su_ready_r[c] <= (DEPTH_C - cnt_nxt[c]) > AFULL_C;
            end
            if (state == S_IDLE && found) begin
                grant <= arb_ch;
                state <= S_XFER;
            end
            if (pop && rd_last) begin
                state  <= S_IDLE;
                rr_ptr <= (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
            end
            if (pop) begin
                ob_tvalid_r <= 1'b1;
                ob_tdata_r  <= rd_entry[DATA_W-1:0];
                ob_tlast_r  <= rd_last;
                ob_tid_r    <= cur_ch;
            end else if (bus.ob_tready) begin
                ob_tvalid_r <= 1'b0;
            end
            frame_stb <= ob_tvalid_r && bus.ob_tready && ob_tlast_r;
            ovfl_err  <= (err_clr ? '0 : ovfl_err) | ovfl_set;
        end
    end

`ifdef CR_SU_MC_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_err <= 1'b0;
        else        par_err <= (err_clr ? 1'b0 : par_err) | (pop && ^rd_entry);
    end
`else
    assign par_err = 1'b0;
`endif
endmodule

// File: tb/tb_cr_su_mc_core.sv
// Directed self-checking bench for cr_su_mc_core (N_CH=4, DATA_W=64, depth 8, afull 2).
module tb_cr_su_mc_core;
    localparam int N_CH   = 4;
    localparam int DATA_W = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            force_ob_bp = 1'b0;
    logic            err_clr = 1'b0;
    logic            frame_stb;
    logic [N_CH-1:0] ovfl_err;
    logic            par_err;
    int              n_chk = 0;
    int              n_pass = 0;
    logic [63:0]     cap_data[$];
    logic [63:0]     cap_id[$];
    logic            cap_last[$];
    int              stb_cnt;

    cr_su_mc_core_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    cr_su_mc_core #(
        .N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(8), .AFULL_SLOTS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .force_ob_bp(force_ob_bp),
        .err_clr(err_clr), .frame_stb(frame_stb), .ovfl_err(ovfl_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.su_in_valid = '0;
        bus.su_in_data  = '0;
        bus.su_in_last  = '0;
    endtask

    task automatic drive(input int ch, input logic [63:0] d, input logic l);
        idle();
        bus.su_in_valid[ch] = 1'b1;
        bus.su_in_data[ch*DATA_W +: DATA_W] = d;
        bus.su_in_last[ch] = l;
    endtask

    task automatic drain(input int cycles);
        cap_data.delete();
        cap_id.delete();
        cap_last.delete();
        stb_cnt = 0;
        repeat (cycles) begin
            if (bus.ob_tvalid && bus.ob_tready) begin
                cap_data.push_back(bus.ob_tdata);
                cap_id.push_back(64'(bus.ob_tid));
                cap_last.push_back(bus.ob_tlast);
            end
            if (frame_stb) stb_cnt++;
            tick();
        end
    endtask

    initial begin
        logic [63:0] rr_d [6];
        logic [63:0] rr_id [6];
        logic        rr_l [6];
        rr_d  = '{64'hA0, 64'hA1, 64'hC0, 64'hC1, 64'hD0, 64'hD1};
        rr_id = '{64'd0, 64'd0, 64'd2, 64'd2, 64'd3, 64'd3};
        rr_l  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        idle();
        bus.ob_tready = 1'b1;
        repeat (2) tick();
        check("rst_tvalid", 64'(bus.ob_tvalid), 64'd0);
        check("rst_su_ready", 64'(bus.su_ready), 64'd0);
        check("rst_errs", 64'({frame_stb, ovfl_err, par_err}), 64'd0);
        rst_n = 1'b1;
        tick();
        check("su_ready_post_rst", 64'(bus.su_ready), 64'hF);

        // single channel, 3-beat frame on ch1
        drive(1, 64'h11, 1'b0); tick();
        check("lat_t1_tvalid", 64'(bus.ob_tvalid), 64'd0);
        drive(1, 64'h22, 1'b0); tick();
        check("b0_beat", {bus.ob_tdata[59:0], 1'(bus.ob_tvalid), bus.ob_tid, bus.ob_tlast},
              {60'h11, 1'b1, 2'd1, 1'b0});
        drive(1, 64'h33, 1'b1); tick();
        check("b1_beat", {bus.ob_tdata[59:0], 1'(bus.ob_tvalid), bus.ob_tid, bus.ob_tlast},
              {60'h22, 1'b1, 2'd1, 1'b0});
        idle(); tick();
        check("b2_beat", {bus.ob_tdata[59:0], 1'(bus.ob_tvalid), bus.ob_tid, bus.ob_tlast},
              {60'h33, 1'b1, 2'd1, 1'b1});
        check("b2_stb", 64'(frame_stb), 64'd0);
        tick();
        check("frame_stb", 64'({frame_stb, bus.ob_tvalid}), 64'b10);
        tick();
        check("frame_stb_once", 64'(frame_stb), 64'd0);

        // round-robin across ch0/ch2/ch3 starting from rr_ptr=0
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        bus.su_in_valid = 4'b1101;
        bus.su_in_data  = {64'hD0, 64'hC0, 64'h0, 64'hA0};
        bus.su_in_last  = 4'b0000;
        tick();
        bus.su_in_data  = {64'hD1, 64'hC1, 64'h0, 64'hA1};
        bus.su_in_last  = 4'b1101;
        tick();
        idle();
        drain(30);
        check("rr_beats", 64'(cap_data.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rr_data%0d", i), cap_data[i], rr_d[i]);
            check($sformatf("rr_id%0d", i), cap_id[i], rr_id[i]);
            check($sformatf("rr_last%0d", i), 64'(cap_last[i]), 64'(rr_l[i]));
        end
        check("rr_stb", 64'(stb_cnt), 64'd3);
        check("rr_ptr_end", 64'(dut.rr_ptr), 64'd0);

        // credit / overflow on ch0 with the output path blocked
        bus.ob_tready = 1'b0;
        force_ob_bp = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            drive(0, 64'h100 + 64'(k), k == 8);
            tick();
            if (k == 5) check("su_ready_w5", 64'(bus.su_ready[0]), 64'd1);
            if (k == 6) check("su_ready_w6", 64'(bus.su_ready[0]), 64'd0);
            if (k == 8) check("ovfl_w8", 64'(ovfl_err), 64'd0);
            if (k == 9) check("ovfl_w9", 64'(ovfl_err), 64'd1);
        end
        check("bp_no_load", 64'(bus.ob_tvalid), 64'd0);
        drive(0, 64'h1FF, 1'b0);
        err_clr = 1'b1;
        tick();
        check("ovfl_set_wins", 64'(ovfl_err), 64'd1);
        idle();
        tick();
        check("ovfl_clr", 64'(ovfl_err), 64'd0);
        err_clr = 1'b0;
        force_ob_bp = 1'b0;
        bus.ob_tready = 1'b1;
        drain(20);
        check("bp_beats", 64'(cap_data.size()), 64'd8);
        check("bp_first", cap_data[0], 64'h101);
        check("bp_last_data", cap_data[7], 64'h108);
        check("bp_last_flag", 64'(cap_last[7]), 64'd1);
        check("bp_stb", 64'(stb_cnt), 64'd1);
        check("bp_su_ready", 64'(bus.su_ready), 64'hF);

        // force_ob_bp holds a presented beat and then blocks pops
        bus.ob_tready = 1'b0;
        drive(1, 64'h51, 1'b0); tick();
        drive(1, 64'h52, 1'b0); tick();
        drive(1, 64'h53, 1'b1); tick();
        idle();
        force_ob_bp = 1'b1;
        tick();
        check("fbp_hold1", {bus.ob_tdata[62:0], 1'(bus.ob_tvalid)}, {63'h51, 1'b1});
        tick();
        check("fbp_hold2", {bus.ob_tdata[62:0], 1'(bus.ob_tvalid)}, {63'h51, 1'b1});
        bus.ob_tready = 1'b1;
        tick();
        check("fbp_accepted", 64'(bus.ob_tvalid), 64'd0);
        repeat (3) tick();
        check("fbp_no_pop", 64'(bus.ob_tvalid), 64'd0);
        check("fbp_fifo_cnt", 64'(dut.cnt[1]), 64'd2);
        force_ob_bp = 1'b0;
        tick();
        check("fbp_resume0", {bus.ob_tdata[62:0], 1'(bus.ob_tlast)}, {63'h52, 1'b0});
        tick();
        check("fbp_resume1", {bus.ob_tdata[62:0], 1'(bus.ob_tlast)}, {63'h53, 1'b1});
        tick();
        check("fbp_stb", 64'({frame_stb, bus.ob_tvalid}), 64'b10);

        // reset in the middle of a 4-beat frame on ch3
        drive(3, 64'h61, 1'b0); tick();
        drive(3, 64'h62, 1'b0); tick();
        drive(3, 64'h63, 1'b0); tick();
        drive(3, 64'h64, 1'b1); tick();
        idle();
        check("mid_presented", bus.ob_tdata, 64'h63);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {bus.ob_tdata[59:0], 1'(bus.ob_tvalid), bus.ob_tlast, bus.ob_tid},
              64'd0);
        check("mid_rst_side", 64'({bus.su_ready, frame_stb, ovfl_err, par_err}), 64'd0);
        check("mid_rst_fifo", 64'(dut.cnt[3]), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_su_ready", 64'(bus.su_ready), 64'hF);
        drain(6);
        check("mid_no_beats", 64'(cap_data.size()), 64'd0);
        check("mid_no_stb", 64'(stb_cnt), 64'd0);

`ifdef CR_SU_MC_PARITY_EN
        force_ob_bp = 1'b1;
        drive(2, 64'hAB, 1'b1); tick();
        idle(); tick();
        dut.mem[2][dut.rd_ptr[2]][5] = ~dut.mem[2][dut.rd_ptr[2]][5];
        check("par_pre", 64'(par_err), 64'd0);
        force_ob_bp = 1'b0;
        drain(6);
        check("par_err_set", 64'(par_err), 64'd1);
        check("par_beat_fwd", cap_data[0], 64'h8B);
`else
        drive(2, 64'hAB, 1'b1); tick();
        idle();
        drain(6);
        check("par_beat", cap_data[0], 64'hAB);
        check("par_err_zero", 64'(par_err), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
